// File: rtl/noc_stream_bridge_if.sv
// Flit types shared by the stream bridge and the router port, plus the bridge's bundled
// stream/router interface. slave is the bridge's view; master is the surrounding system's.
package noc_stream_bridge_pkg;
   localparam int FLIT_DATA_SIZE = 32;
   localparam int VC_NUM         = 2;
   localparam int VC_SIZE        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

   typedef enum logic [1:0] {
      HEAD     = 2'b00,
      BODY     = 2'b01,
      TAIL     = 2'b10,
      HEADTAIL = 2'b11
   } flit_label_t;

   typedef struct packed {
      flit_label_t               flit_label;
      logic [VC_SIZE-1:0]        vc_id;
      logic [FLIT_DATA_SIZE-1:0] data;
   } flit_t;
endpackage

interface noc_stream_bridge_if;
   import noc_stream_bridge_pkg::*;

   logic                      tx_valid;
   logic                      tx_ready;
   logic [FLIT_DATA_SIZE-1:0] tx_data;

   flit_t                     router_data_in;
   logic                      router_valid_in;
   logic [VC_NUM-1:0]         router_is_on_off_in;
   logic [VC_NUM-1:0]         router_is_allocatable_in;

   flit_t                     router_data_out;
   logic                      router_valid_out;
   logic [VC_NUM-1:0]         router_is_on_off_out;
   logic [VC_NUM-1:0]         router_is_allocatable_out;

   logic                      rx_valid;
   logic                      rx_ready;
   logic [FLIT_DATA_SIZE-1:0] rx_data;
   logic                      rx_last;
   logic                      rx_head;
   logic                      rx_overflow;

   modport slave (
      input  tx_valid, tx_data,
      input  router_data_out, router_valid_out, router_is_on_off_out, router_is_allocatable_out,
      input  rx_ready,
      output tx_ready,
      output router_data_in, router_valid_in, router_is_on_off_in, router_is_allocatable_in,
      output rx_valid, rx_data, rx_last, rx_head, rx_overflow
   );

   modport master (
      output tx_valid, tx_data,
      output router_data_out, router_valid_out, router_is_on_off_out, router_is_allocatable_out,
      output rx_ready,
      input  tx_ready,
      input  router_data_in, router_valid_in, router_is_on_off_in, router_is_allocatable_in,
      input  rx_valid, rx_data, rx_last, rx_head, rx_overflow
   );
endinterface

// File: rtl/noc_stream_bridge.sv
// Word-stream <-> NoC local-port bridge: TX packetises header+payload words into flits,
// RX de-packetises flits into a small FWFT buffer that drives on/off back-pressure.
module noc_stream_bridge
   import noc_stream_bridge_pkg::*;
#(
   parameter int TX_VC        = 0,
   parameter int LEN_W        = 5,
   parameter int RX_DEPTH     = 4,
   parameter int RX_MARGIN    = 2,
   parameter int RX_KEEP_HEAD = 0
) (
   input  logic                clk_router,
   input  logic                rst_router,
   noc_stream_bridge_if.slave  link
);
   localparam int DW    = FLIT_DATA_SIZE;
   localparam int PTR_W = $clog2(RX_DEPTH);
   localparam int CNT_W = $clog2(RX_DEPTH + 1);
   localparam logic [VC_SIZE-1:0] TX_VC_ID = VC_SIZE'(TX_VC);

   typedef enum logic {ST_IDLE, ST_BODY} tx_state_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic          head;
   } rx_entry_t;

   // ---------------------------------------------------------------- TX
   tx_state_t        state_q;
   logic [LEN_W-1:0] remaining_q;
   logic             router_valid_q;
   flit_t            router_data_q;
   logic             tx_ready;
   logic             tx_fire;
   logic [LEN_W-1:0] hdr_len;

   assign hdr_len = link.tx_data[DW-9 -: LEN_W];
   assign tx_fire = link.tx_valid & tx_ready;

   always_comb begin
      // NOTE: default first so no path leaves tx_ready unassigned (would infer a latch).
      tx_ready = 1'b0;
      unique case (state_q)
         ST_IDLE: tx_ready = link.router_is_on_off_out[TX_VC] & link.router_is_allocatable_out[TX_VC];
         ST_BODY: tx_ready = link.router_is_on_off_out[TX_VC];
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_router or posedge rst_router) begin
      if (rst_router) begin
         state_q        <= ST_IDLE;
         remaining_q    <= '0;
         router_valid_q <= 1'b0;
         router_data_q  <= '{flit_label: HEADTAIL, vc_id: '0, data: '0};
      end else begin
         router_valid_q <= tx_fire;
         if (tx_fire) begin
            router_data_q.vc_id <= TX_VC_ID;
            router_data_q.data  <= link.tx_data;
            unique case (state_q)
               ST_IDLE: begin
                  if (hdr_len == '0) begin
                     router_data_q.flit_label <= HEADTAIL;
                  end else begin
                     router_data_q.flit_label <= HEAD;
                     remaining_q              <= hdr_len;
                     state_q                  <= ST_BODY;
                  end
               end
               ST_BODY: begin
                  remaining_q <= remaining_q - LEN_W'(1);
                  if (remaining_q == LEN_W'(1)) begin
                     router_data_q.flit_label <= TAIL;
                     state_q                  <= ST_IDLE;
                  end else begin
                     router_data_q.flit_label <= BODY;
                  end
               end
            endcase
         end
      end
   end

   assign link.tx_ready                 = tx_ready;
   assign link.router_valid_in          = router_valid_q;
   assign link.router_data_in           = router_data_q;
   assign link.router_is_allocatable_in = '1;

   // ---------------------------------------------------------------- RX
   rx_entry_t         mem_q [RX_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [VC_NUM-1:0] on_off_q;
   logic              overflow_q;
   flit_t             rx_flit;
   logic              rx_is_head, rx_is_last;
   logic              want_push, push, pop, rx_valid;

   assign rx_flit    = link.router_data_out;
   assign rx_is_head = (rx_flit.flit_label == HEAD) || (rx_flit.flit_label == HEADTAIL);
   assign rx_is_last = (rx_flit.flit_label == TAIL) || (rx_flit.flit_label == HEADTAIL);
   assign want_push  = link.router_valid_out & (~rx_is_head | (RX_KEEP_HEAD != 0));
   assign rx_valid   = (count_q != '0);
   assign pop        = rx_valid & link.rx_ready;
   // A full buffer still takes a flit when the head entry leaves in the same cycle.
   assign push       = want_push & ((count_q != CNT_W'(RX_DEPTH)) | pop);

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk_router or posedge rst_router) begin
      if (rst_router) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         on_off_q   <= '1;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q  <= count_d;
         on_off_q <= {VC_NUM{(RX_DEPTH - int'(count_d)) > RX_MARGIN}};
         if (want_push && !push) overflow_q <= 1'b1;
      end
   end

   // NOTE: buffer storage has no reset; count/pointers alone decide which entries are valid.
   always_ff @(posedge clk_router) begin
      if (push) mem_q[wr_ptr_q] <= '{data: rx_flit.data, last: rx_is_last, head: rx_is_head};
   end

   assign link.rx_valid            = rx_valid;
   assign link.rx_data             = mem_q[rd_ptr_q].data;
   assign link.rx_last             = mem_q[rd_ptr_q].last;
   assign link.rx_head             = mem_q[rd_ptr_q].head;
   assign link.rx_overflow         = overflow_q;
   assign link.router_is_on_off_in = on_off_q;
endmodule
